// File: rtl/rv_pl_pkg.sv
// Shared definitions for the rv_pl core and its boot/run sequencer.
package rv_pl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RELEASE = 3'd2,
      ST_RUN     = 3'd3,
      ST_DONE    = 3'd4
   } boot_state_e;

   localparam logic [31:0] HALT_ADDR_DEFAULT = 32'hFFFF_FFF0;

endpackage

// File: rtl/rv_boot_ctrl.sv
// Boot and run sequencer for rv_pl: streams a program into IMEM, releases the
// core, and watches the memory stage for the halt store.
//
// state   | meaning
// IDLE    | after reset, core held in reset, waiting for start_load
// LOAD    | accepting program words and writing them to IMEM
// RELEASE | core reset held for RST_HOLD cycles while the last write settles
// RUN     | core running, cycle counter active, halt/abort/timeout watched
// DONE    | core held in reset, status frozen until start_load or start_run
module rv_boot_ctrl
   import rv_pl_pkg::*;
#(
   parameter int          IMEM_WORDS = 1024,
   parameter int          AW         = $clog2(IMEM_WORDS),
   parameter logic [31:0] HALT_ADDR  = HALT_ADDR_DEFAULT,
   parameter logic [31:0] TIMEOUT    = 32'd0,
   parameter int          RST_HOLD   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_load,
   input  logic          start_run,
   input  logic          abort,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [31:0]   ld_data,
   input  logic          ld_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          core_rst_n,
   input  logic          M_MemWrite,
   input  logic [31:0]   M_ALUResult,
   input  logic [31:0]   M_WriteData,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic          aborted,
   output logic          load_trunc,
   output logic [31:0]   exit_code,
   output logic [31:0]   cycle_count,
   output logic [AW:0]   words_loaded
);

   localparam logic [AW:0] WORDS_MAX  = (AW+1)'(IMEM_WORDS);
   localparam logic [AW:0] WORDS_LAST = (AW+1)'(IMEM_WORDS - 1);
   localparam logic [AW:0] WORDS_ONE  = (AW+1)'(1);
   localparam logic [7:0]  HOLD_INIT  = 8'(RST_HOLD - 1);

   boot_state_e state_q, state_d;

   logic [7:0]    hold_q, hold_d;
   logic          imem_we_d;
   logic [AW-1:0] imem_addr_d;
   logic [31:0]   imem_wdata_d;
   logic [AW:0]   words_d;
   logic [31:0]   cycle_d;
   logic [31:0]   exit_d;
   logic          done_d, timeout_d, aborted_d, trunc_d;

   logic xfer, last_slot, halt_hit, timeout_hit;

   // ready depends only on state and count, never on ld_valid
   assign ld_ready    = (state_q == ST_LOAD) && (words_loaded < WORDS_MAX);
   assign xfer        = ld_valid && ld_ready;
   assign last_slot   = (words_loaded == WORDS_LAST);
   assign halt_hit    = M_MemWrite && (M_ALUResult == HALT_ADDR);
   assign timeout_hit = (TIMEOUT != 32'd0) && (cycle_count == TIMEOUT - 32'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         hold_q       <= 8'd0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= 32'd0;
         words_loaded <= '0;
         cycle_count  <= 32'd0;
         exit_code    <= 32'd0;
         done         <= 1'b0;
         timeout      <= 1'b0;
         aborted      <= 1'b0;
         load_trunc   <= 1'b0;
         core_rst_n   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         imem_we      <= imem_we_d;
         imem_addr    <= imem_addr_d;
         imem_wdata   <= imem_wdata_d;
         words_loaded <= words_d;
         cycle_count  <= cycle_d;
         exit_code    <= exit_d;
         done         <= done_d;
         timeout      <= timeout_d;
         aborted      <= aborted_d;
         load_trunc   <= trunc_d;
         core_rst_n   <= (state_d == ST_RUN);
         busy         <= (state_d == ST_LOAD) || (state_d == ST_RELEASE) ||
                         (state_d == ST_RUN);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_load) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (xfer && (ld_last || last_slot)) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (hold_q == 8'd0) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (halt_hit || abort || timeout_hit) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (start_load)     state_d = ST_LOAD;
            else if (start_run) state_d = ST_RELEASE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hold_d       = hold_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr;
      imem_wdata_d = imem_wdata;
      words_d      = words_loaded;
      cycle_d      = cycle_count;
      exit_d       = exit_code;
      done_d       = done;
      timeout_d    = timeout;
      aborted_d    = aborted;
      trunc_d      = load_trunc;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_load) begin
               words_d   = '0;
               done_d    = 1'b0;
               timeout_d = 1'b0;
               aborted_d = 1'b0;
               trunc_d   = 1'b0;
            end else if ((state_q == ST_DONE) && start_run) begin
               // rerun keeps the image, words_loaded and load_trunc
               hold_d    = HOLD_INIT;
               exit_d    = 32'd0;
               done_d    = 1'b0;
               timeout_d = 1'b0;
               aborted_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = words_loaded[AW-1:0];
               imem_wdata_d = ld_data;
               words_d      = words_loaded + WORDS_ONE;
               hold_d       = HOLD_INIT;
               if (!ld_last && last_slot) trunc_d = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (hold_q == 8'd0) cycle_d = 32'd0;
            else                hold_d  = hold_q - 8'd1;
         end
         ST_RUN: begin
            if (cycle_count != 32'hFFFF_FFFF) cycle_d = cycle_count + 32'd1;
            if (halt_hit) begin
               exit_d = M_WriteData;
               done_d = 1'b1;
            end else if (abort) begin
               aborted_d = 1'b1;
            end else if (timeout_hit) begin
               timeout_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rv_boot_ctrl.sv
// Bench for rv_boot_ctrl: timeline-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized load/run rounds.
module tb_rv_boot_ctrl;

   localparam int          N    = 4;
   localparam int          AW   = 2;
   localparam logic [31:0] HALT = 32'hFFFF_FFF0;
   localparam int          TO   = 10;
   localparam int          HOLD = 4;

   localparam int MD_IDLE = 0, MD_LOAD = 1, MD_HOLD = 2, MD_RUN = 3, MD_DONE = 4;
   localparam int EV_HALT = 0, EV_ABORT = 1, EV_BOTH = 2, EV_NONE = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_load = 1'b0, start_run = 1'b0, abort = 1'b0;
   logic          ld_valid = 1'b0, ld_last = 1'b0;
   logic [31:0]   ld_data = 32'd0;
   logic          M_MemWrite = 1'b0;
   logic [31:0]   M_ALUResult = 32'd0, M_WriteData = 32'd0;
   logic          ld_ready, imem_we, core_rst_n;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata, exit_code, cycle_count;
   logic          busy, done, timeout, aborted, load_trunc;
   logic [AW:0]   words_loaded;

   rv_boot_ctrl #(
      .IMEM_WORDS(N), .HALT_ADDR(HALT), .TIMEOUT(32'(TO)), .RST_HOLD(HOLD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_run(start_run),
      .abort(abort), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .ld_last(ld_last), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .M_MemWrite(M_MemWrite),
      .M_ALUResult(M_ALUResult), .M_WriteData(M_WriteData), .busy(busy),
      .done(done), .timeout(timeout), .aborted(aborted), .load_trunc(load_trunc),
      .exit_code(exit_code), .cycle_count(cycle_count), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic expired(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired, required event never seen at %0t", nm, $time);
   endtask

   // Reference model: mode plus timestamps of release/run entry
   int          m_mode = MD_IDLE, m_words = 0, m_addr = 0, m_cc = 0;
   int          cyc = 0, m_t_rel = 0, m_t_run = 0, m_pre = 0;
   bit          m_trunc = 0, m_done = 0, m_to = 0, m_ab = 0, m_we = 0;
   logic [31:0] m_exit = 32'd0, m_wdata = 32'd0;

   function automatic void enter_load();
      m_mode = MD_LOAD; m_words = 0;
      m_done = 0; m_to = 0; m_ab = 0; m_trunc = 0;
   endfunction

   function automatic void enter_hold();
      m_mode  = MD_HOLD;
      m_t_rel = cyc;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = MD_IDLE; m_words = 0; m_addr = 0; m_cc = 0;
         cyc = 0; m_t_rel = 0; m_t_run = 0;
         m_trunc = 0; m_done = 0; m_to = 0; m_ab = 0; m_we = 0;
         m_exit = 32'd0; m_wdata = 32'd0;
      end else begin
         cyc++;
         m_we = 0;
         case (m_mode)
            MD_IDLE: if (start_load) enter_load();
            MD_LOAD: begin
               if (ld_valid && m_words < N) begin
                  m_we = 1; m_addr = m_words; m_wdata = ld_data;
                  m_words++;
                  if (ld_last) enter_hold();
                  else if (m_words == N) begin
                     m_trunc = 1;
                     enter_hold();
                  end
               end
            end
            MD_HOLD: begin
               if (cyc - m_t_rel == HOLD) begin
                  m_mode = MD_RUN; m_t_run = cyc; m_cc = 0;
               end
            end
            MD_RUN: begin
               m_pre = cyc - 1 - m_t_run;
               m_cc  = cyc - m_t_run;
               if (M_MemWrite && M_ALUResult == HALT) begin
                  m_exit = M_WriteData; m_done = 1; m_mode = MD_DONE;
               end else if (abort) begin
                  m_ab = 1; m_mode = MD_DONE;
               end else if (TO != 0 && m_pre == TO - 1) begin
                  m_to = 1; m_mode = MD_DONE;
               end
            end
            MD_DONE: begin
               if (start_load) enter_load();
               else if (start_run) begin
                  enter_hold();
                  m_done = 0; m_to = 0; m_ab = 0; m_exit = 32'd0;
               end
            end
            default: m_mode = MD_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      check("core_rst_n",   32'(core_rst_n),   32'(m_mode == MD_RUN));
      check("busy",         32'(busy),         32'(m_mode >= MD_LOAD && m_mode <= MD_RUN));
      check("ld_ready",     32'(ld_ready),     32'(m_mode == MD_LOAD && m_words < N));
      check("imem_we",      32'(imem_we),      32'(m_we));
      check("imem_addr",    32'(imem_addr),    32'(m_addr));
      check("imem_wdata",   imem_wdata,        m_wdata);
      check("words_loaded", 32'(words_loaded), 32'(m_words));
      check("done",         32'(done),         32'(m_done));
      check("timeout",      32'(timeout),      32'(m_to));
      check("aborted",      32'(aborted),      32'(m_ab));
      check("load_trunc",   32'(load_trunc),   32'(m_trunc));
      check("exit_code",    exit_code,         m_exit);
      check("cycle_count",  cycle_count,       32'(m_cc));
   end

   int wr_addrs[$];
   always @(negedge clk) if (rst_n && imem_we) wr_addrs.push_back(int'(imem_addr));

   logic [31:0] beats [8];

   task automatic pulse(input bit sl, input bit sr);
      @(negedge clk);
      start_load = sl; start_run = sr;
      @(negedge clk);
      start_load = 1'b0; start_run = 1'b0;
   endtask

   task automatic stream(input int n, input int last_idx, input bit gaps);
      int idx = 0;
      for (int t = 0; t < 80 && idx < n; t++) begin
         @(negedge clk);
         if (!ld_ready) break;
         ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         ld_data  = beats[idx];
         ld_last  = (idx == last_idx);
         abort    = 1'($urandom_range(0, 1));
         if (ld_valid) idx++;
      end
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0; abort = 1'b0;
   endtask

   task automatic run_phase(input int ev, input int dly, input logic [31:0] val);
      bit fin = 0;
      for (int t = 0; t < 40 && !core_rst_n; t++) @(negedge clk);
      if (!core_rst_n) expired("run_start");
      for (int c = 0; c < 40; c++) begin
         M_MemWrite  = 1'($urandom_range(0, 1));
         M_ALUResult = ($urandom_range(0, 3) == 0) ? HALT : ($urandom() & 32'h7FFF_FFFC);
         if (M_ALUResult == HALT) M_MemWrite = 1'b0;
         M_WriteData = $urandom();
         start_load  = ($urandom_range(0, 7) == 0);
         start_run   = ($urandom_range(0, 7) == 0);
         abort       = 1'b0;
         if (c == dly) begin
            if (ev == EV_HALT || ev == EV_BOTH) begin
               M_MemWrite = 1'b1; M_ALUResult = HALT; M_WriteData = val;
            end
            if (ev == EV_ABORT || ev == EV_BOTH) abort = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         M_MemWrite = 1'b0; M_ALUResult = 32'd0; start_load = 1'b0;
         start_run = 1'b0; abort = 1'b0;
         if (!busy) begin
            fin = 1;
            break;
         end
      end
      if (!fin) expired("run_end");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, nw, op, n, li;
      repeat (3) @(negedge clk);
      check("rst_core_rst_n",   32'(core_rst_n),   32'd0);
      check("rst_busy",         32'(busy),         32'd0);
      check("rst_ld_ready",     32'(ld_ready),     32'd0);
      check("rst_words_loaded", 32'(words_loaded), 32'd0);
      rst_n = 1'b1;

      // start_run has no effect from IDLE
      pulse(0, 1);
      @(negedge clk);
      check("idle_start_run_busy", 32'(busy), 32'd0);

      // load three words and halt with exit code 5
      beats[0] = 32'h0050_0093; beats[1] = 32'hFE00_0113; beats[2] = 32'h0011_2023;
      wr_addrs.delete();
      pulse(1, 0);
      stream(3, 2, 0);
      k = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         k++;
         if (core_rst_n) break;
      end
      check("release_cycles", 32'(k), 32'd4);
      check("load_writes", 32'(wr_addrs.size()), 32'd3);
      for (int i = 0; i < 3 && i < wr_addrs.size(); i++)
         check("load_addr", 32'(wr_addrs[i]), 32'(i));
      check("load_words_loaded", 32'(words_loaded), 32'd3);
      run_phase(EV_HALT, 2, 32'd5);
      check("halt_exit_code",  exit_code,        32'd5);
      check("halt_done",       32'(done),        32'd1);
      check("halt_core_rst_n", 32'(core_rst_n),  32'd0);

      // rerun: halt and abort together, only done
      nw = wr_addrs.size();
      pulse(0, 1);
      run_phase(EV_BOTH, 1, 32'h0000_00A5);
      check("conflict_done",    32'(done),    32'd1);
      check("conflict_aborted", 32'(aborted), 32'd0);
      check("conflict_timeout", 32'(timeout), 32'd0);
      check("rerun_no_writes",  32'(wr_addrs.size()), 32'(nw));

      // timeout with no halt
      pulse(0, 1);
      run_phase(EV_NONE, 0, 32'd0);
      check("to_timeout",     32'(timeout),  32'd1);
      check("to_cycle_count", cycle_count,   32'd10);
      check("to_done",        32'(done),     32'd0);

      pulse(0, 1);
      run_phase(EV_ABORT, 3, 32'd0);
      check("abort_aborted", 32'(aborted), 32'd1);

      // both pulses from DONE enter LOAD, then truncation
      pulse(1, 1);
      check("both_busy",     32'(busy),         32'd1);
      check("both_ld_ready", 32'(ld_ready),     32'd1);
      check("both_words",    32'(words_loaded), 32'd0);
      for (int i = 0; i < 8; i++) beats[i] = $urandom();
      wr_addrs.delete();
      stream(6, -1, 0);
      repeat (2) @(negedge clk);
      check("trunc_writes",   32'(wr_addrs.size()), 32'd4);
      check("trunc_flag",     32'(load_trunc),      32'd1);
      check("trunc_ld_ready", 32'(ld_ready),        32'd0);
      run_phase($urandom_range(0, 3), $urandom_range(0, 12), $urandom());

      repeat (25) begin
         op = $urandom_range(0, 2);
         if (op != 1) begin
            n = $urandom_range(1, 6);
            if (n >= 4 && $urandom_range(0, 1) == 1) li = -1;
            else begin
               li = $urandom_range(0, n - 1);
               n  = li + 1;
            end
            for (int i = 0; i < 8; i++) beats[i] = $urandom();
            pulse(1, op == 2);
            stream(n, li, 1);
         end else begin
            pulse(0, 1);
         end
         run_phase($urandom_range(0, 3), $urandom_range(0, 12), $urandom());
      end

      // reset in the middle of a load
      for (int i = 0; i < 8; i++) beats[i] = $urandom();
      pulse(1, 0);
      stream(2, -1, 0);
      check("midload_words", 32'(words_loaded), 32'd2);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("mrst_busy",       32'(busy),         32'd0);
      check("mrst_core_rst_n", 32'(core_rst_n),   32'd0);
      check("mrst_ld_ready",   32'(ld_ready),     32'd0);
      check("mrst_words",      32'(words_loaded), 32'd0);
      check("mrst_imem_addr",  32'(imem_addr),    32'd0);
      check("mrst_exit_code",  exit_code,         32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
